// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Multiplies are radix-2 shift-add and divides are restoring, one bit per cycle, followed by a sign fix-up cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic             is_signed,
  input  logic             abort,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             rd_hi,
  input  logic             rd_lo,
  input  logic             wr_hi,
  input  logic             wr_lo,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH-1:0]   r_srcaRaw;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_isDiv;
  logic               r_negRes;
  logic               r_negRem;
  logic               r_divZero;
  logic               r_busy;
  logic               r_done;

  logic               w_signA;
  logic               w_signB;
  logic [WIDTH-1:0]   w_magA;
  logic [WIDTH-1:0]   w_magB;
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH:0]     w_mulSum;
  logic [2*WIDTH-1:0] w_mulNext;
  logic [WIDTH:0]     w_remShift;
  logic [WIDTH:0]     w_diff;
  logic               w_qBit;
  logic [2*WIDTH-1:0] w_divNext;
  logic [2*WIDTH-1:0] w_prodFix;
  logic [WIDTH-1:0]   w_quoMag;
  logic [WIDTH-1:0]   w_remMag;
  logic [WIDTH-1:0]   w_quoFix;
  logic [WIDTH-1:0]   w_remFix;

  // Both datapaths work on magnitudes; signs are reapplied in FIX.
  assign w_signA = is_signed & srca[WIDTH-1];
  assign w_signB = is_signed & srcb[WIDTH-1];
  assign w_magA  = w_signA ? -srca : srca;
  assign w_magB  = w_signB ? -srcb : srcb;

  assign w_addend  = r_acc[0] ? r_opnd : '0;
  assign w_mulSum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
  assign w_mulNext = {w_mulSum, r_acc[WIDTH-1:1]};

  // Upper half of the accumulator is the partial remainder, lower half shifts dividend out and quotient in.
  assign w_remShift = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_diff     = w_remShift - {1'b0, r_opnd};
  assign w_qBit     = ~w_diff[WIDTH];
  assign w_divNext  = {(w_qBit ? w_diff[WIDTH-1:0] : w_remShift[WIDTH-1:0]), r_acc[WIDTH-2:0], w_qBit};

  assign w_prodFix = r_negRes ? -r_acc : r_acc;
  assign w_quoMag  = r_acc[WIDTH-1:0];
  assign w_remMag  = r_acc[2*WIDTH-1:WIDTH];
  assign w_quoFix  = r_negRes ? -w_quoMag : w_quoMag;
  assign w_remFix  = r_negRem ? -w_remMag : w_remMag;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_opnd    <= '0;
      r_srcaRaw <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_isDiv   <= 1'b0;
      r_negRes  <= 1'b0;
      r_negRem  <= 1'b0;
      r_divZero <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (wr_hi) r_hi <= srca;
          if (wr_lo) r_lo <= srca;
          if (!abort && (start_mult || start_div)) begin
            r_state   <= start_mult ? S_MUL : S_DIV;
            r_busy    <= 1'b1;
            r_cnt     <= '0;
            r_isDiv   <= !start_mult;
            r_opnd    <= start_mult ? w_magA : w_magB;
            r_acc     <= {{WIDTH{1'b0}}, (start_mult ? w_magB : w_magA)};
            r_negRes  <= w_signA ^ w_signB;
            r_negRem  <= w_signA;
            r_divZero <= (srcb == '0);
            r_srcaRaw <= srca;
          end
        end
        S_MUL, S_DIV: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_acc <= (r_state == S_MUL) ? w_mulNext : w_divNext;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == LAST_CNT) r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          if (!abort) begin
            r_done <= 1'b1;
            if (!r_isDiv) begin
              {r_hi, r_lo} <= w_prodFix;
            end else if (r_divZero) begin
              r_hi <= r_srcaRaw;
              r_lo <= '1;
            end else begin
              r_hi <= w_remFix;
              r_lo <= w_quoFix;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign hi     = r_hi;
  assign lo     = r_lo;
  assign busy   = r_busy;
  assign done   = r_done;
  assign result = rd_hi ? r_hi : (rd_lo ? r_lo : '0);
  assign stall  = r_busy & (rd_hi | rd_lo | wr_hi | wr_lo | start_mult | start_div);

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench: directed WIDTH=32 scenarios plus randomized WIDTH=8 operations against an arithmetic model.
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        aStartMult, aStartDiv, aSigned, aAbort, aRdHi, aRdLo, aWrHi, aWrLo;
  logic [31:0] aSrca, aSrcb, aResult, aHi, aLo;
  logic        aBusy, aDone, aStall;

  logic        eStartMult, eStartDiv, eSigned, eAbort, eRdHi, eRdLo, eWrHi, eWrLo;
  logic [7:0]  eSrca, eSrcb, eResult, eHi, eLo;
  logic        eBusy, eDone, eStall;

  int errors = 0;
  int checks = 0;

  muldiv_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .reset_n(reset_n), .start_mult(aStartMult), .start_div(aStartDiv),
    .is_signed(aSigned), .abort(aAbort), .srca(aSrca), .srcb(aSrcb),
    .rd_hi(aRdHi), .rd_lo(aRdLo), .wr_hi(aWrHi), .wr_lo(aWrLo),
    .result(aResult), .hi(aHi), .lo(aLo), .busy(aBusy), .done(aDone), .stall(aStall)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .start_mult(eStartMult), .start_div(eStartDiv),
    .is_signed(eSigned), .abort(eAbort), .srca(eSrca), .srcb(eSrcb),
    .rd_hi(eRdHi), .rd_lo(eRdLo), .wr_hi(eWrHi), .wr_lo(eWrLo),
    .result(eResult), .hi(eHi), .lo(eLo), .busy(eBusy), .done(eDone), .stall(eStall)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: full-precision integer arithmetic, truncated to the unit width.
  function automatic void refOp(input int w, input bit isDiv, input bit sgn,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] expHi, output logic [31:0] expLo);
    longint mask = (longint'(1) << w) - 1;
    longint sa, sb, p, q, r;
    sa = longint'(a) & mask;
    sb = longint'(b) & mask;
    if (sgn && a[w-1]) sa = sa | ~mask;
    if (sgn && b[w-1]) sb = sb | ~mask;
    if (!isDiv) begin
      p = sa * sb;
      expHi = 32'((p >>> w) & mask);
      expLo = 32'(p & mask);
    end else if (sb == 0) begin
      expHi = 32'(sa & mask);
      expLo = 32'(mask);
    end else begin
      q = sa / sb;
      r = sa % sb;
      expHi = 32'(r & mask);
      expLo = 32'(q & mask);
    end
  endfunction

  task automatic startOp32(input bit isDiv, input bit sgn, input logic [31:0] a, input logic [31:0] b);
    aStartMult = !isDiv;
    aStartDiv  = isDiv;
    aSigned    = sgn;
    aSrca      = a;
    aSrcb      = b;
    tick();
    aStartMult = 1'b0;
    aStartDiv  = 1'b0;
  endtask

  task automatic waitDone32(output int cycles, output bit stallAll);
    cycles = 0;
    stallAll = 1'b1;
    while (aBusy && cycles < 200) begin
      cycles++;
      if (!aStall) stallAll = 1'b0;
      tick();
    end
  endtask

  task automatic applyStimulus(input string tag, input bit isDiv, input bit sgn,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] expHi, input logic [31:0] expLo);
    int cycles;
    bit stallAll;
    startOp32(isDiv, sgn, a, b);
    waitDone32(cycles, stallAll);
    checkOutput({tag, " busyCycles"}, 64'(cycles), 64'd33);
    checkOutput({tag, " done"}, 64'(aDone), 64'd1);
    checkOutput({tag, " hi"}, 64'(aHi), 64'(expHi));
    checkOutput({tag, " lo"}, 64'(aLo), 64'(expLo));
  endtask

  task automatic startOp8(input bit isDiv, input bit sgn, input logic [7:0] a, input logic [7:0] b);
    eStartMult = !isDiv;
    eStartDiv  = isDiv;
    eSigned    = sgn;
    eSrca      = a;
    eSrcb      = b;
    tick();
    eStartMult = 1'b0;
    eStartDiv  = 1'b0;
  endtask

  initial begin
    int cycles;
    bit stallAll;
    bit doneSeen;
    logic [31:0] savedHi, savedLo, expHi, expLo;
    logic [7:0] ra, rb;
    bit rDiv, rSgn;

    {aStartMult, aStartDiv, aSigned, aAbort, aRdHi, aRdLo, aWrHi, aWrLo} = '0;
    {eStartMult, eStartDiv, eSigned, eAbort, eRdHi, eRdLo, eWrHi, eWrLo} = '0;
    aSrca = '0; aSrcb = '0; eSrca = '0; eSrcb = '0;

    #12;
    checkOutput("reset hi", 64'(aHi), 64'd0);
    checkOutput("reset lo", 64'(aLo), 64'd0);
    checkOutput("reset busy", 64'(aBusy), 64'd0);
    checkOutput("reset done", 64'(aDone), 64'd0);
    checkOutput("reset8 busy", 64'(eBusy), 64'd0);
    reset_n = 1'b1;
    tick();

    applyStimulus("multu max", 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    applyStimulus("mult -3x5", 1'b0, 1'b1, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
    applyStimulus("div -7/2", 1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    applyStimulus("divu 7/2", 1'b1, 1'b0, 32'd7, 32'd2, 32'd1, 32'd3);
    applyStimulus("divu 100/0", 1'b1, 1'b0, 32'd100, 32'd0, 32'h00000064, 32'hFFFFFFFF);
    applyStimulus("div -100/0", 1'b1, 1'b1, 32'hFFFFFF9C, 32'd0, 32'hFFFFFF9C, 32'hFFFFFFFF);
    applyStimulus("div ovf", 1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    applyStimulus("div 7/-2", 1'b1, 1'b1, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD);
    applyStimulus("done after", 1'b0, 1'b0, 32'd0, 32'd5, 32'd0, 32'd0);
    tick();
    checkOutput("done pulse width", 64'(aDone), 64'd0);

    startOp32(1'b0, 1'b0, 32'd6, 32'd7);
    aRdLo = 1'b1;
    #1;
    waitDone32(cycles, stallAll);
    checkOutput("rd_lo stall held", 64'(stallAll), 64'd1);
    checkOutput("rd_lo result on done", 64'(aResult), 64'd42);
    checkOutput("rd_lo done", 64'(aDone), 64'd1);
    aRdLo = 1'b0;

    startOp32(1'b0, 1'b1, 32'hFFFFFFFD, 32'd5);
    repeat (4) tick();
    aStartDiv = 1'b1;
    aSrca = 32'd100;
    aSrcb = 32'd7;
    #1;
    checkOutput("start while busy stall", 64'(aStall), 64'd1);
    tick();
    aStartDiv = 1'b0;
    waitDone32(cycles, stallAll);
    checkOutput("ignored start hi", 64'(aHi), 64'(32'hFFFFFFFF));
    checkOutput("ignored start lo", 64'(aLo), 64'(32'hFFFFFFF1));
    tick();
    checkOutput("ignored start no 2nd op", 64'(aBusy), 64'd0);

    aStartMult = 1'b1;
    aStartDiv = 1'b1;
    aSigned = 1'b0;
    aSrca = 32'd6;
    aSrcb = 32'd7;
    tick();
    aStartMult = 1'b0;
    aStartDiv = 1'b0;
    waitDone32(cycles, stallAll);
    checkOutput("mult wins lo", 64'(aLo), 64'd42);
    checkOutput("mult wins hi", 64'(aHi), 64'd0);

    aWrHi = 1'b1;
    aSrca = 32'h1234;
    tick();
    aWrHi = 1'b0;
    aRdHi = 1'b1;
    aRdLo = 1'b1;
    #1;
    checkOutput("mthi mfhi", 64'(aResult), 64'h1234);
    checkOutput("mthi lo kept", 64'(aLo), 64'd42);
    aRdHi = 1'b0;
    aRdLo = 1'b0;
    aWrHi = 1'b1;
    aWrLo = 1'b1;
    aSrca = 32'hABCD;
    tick();
    aWrHi = 1'b0;
    aWrLo = 1'b0;
    checkOutput("mthi+mtlo hi", 64'(aHi), 64'hABCD);
    checkOutput("mthi+mtlo lo", 64'(aLo), 64'hABCD);

    aStartMult = 1'b1;
    aAbort = 1'b1;
    tick();
    aStartMult = 1'b0;
    aAbort = 1'b0;
    checkOutput("idle abort suppresses start", 64'(aBusy), 64'd0);

    savedHi = aHi;
    savedLo = aLo;
    startOp32(1'b1, 1'b0, 32'd1000, 32'd3);
    repeat (10) tick();
    aAbort = 1'b1;
    tick();
    aAbort = 1'b0;
    checkOutput("abort busy", 64'(aBusy), 64'd0);
    checkOutput("abort hi", 64'(aHi), 64'(savedHi));
    checkOutput("abort lo", 64'(aLo), 64'(savedLo));
    doneSeen = 1'b0;
    repeat (40) begin
      tick();
      if (aDone) doneSeen = 1'b1;
    end
    checkOutput("abort no done", 64'(doneSeen), 64'd0);

    startOp32(1'b0, 1'b0, 32'hFFFFFFFF, 32'd3);
    repeat (19) tick();
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async reset hi", 64'(aHi), 64'd0);
    checkOutput("async reset lo", 64'(aLo), 64'd0);
    checkOutput("async reset busy", 64'(aBusy), 64'd0);
    #2;
    reset_n = 1'b1;
    tick();

    for (int k = 0; k < 80; k++) begin
      rDiv = 1'($urandom_range(0, 1));
      rSgn = 1'($urandom_range(0, 1));
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (k % 10 == 0) rb = 8'd0;
      if (k % 10 == 5) begin
        rDiv = 1'b1;
        rSgn = 1'b1;
        ra = 8'h80;
        rb = 8'hFF;
      end
      refOp(8, rDiv, rSgn, {24'd0, ra}, {24'd0, rb}, expHi, expLo);
      startOp8(rDiv, rSgn, ra, rb);
      cycles = 0;
      while (eBusy && cycles < 50) begin
        cycles++;
        tick();
      end
      checkOutput($sformatf("rand%0d busyCycles", k), 64'(cycles), 64'd9);
      checkOutput($sformatf("rand%0d done", k), 64'(eDone), 64'd1);
      checkOutput($sformatf("rand%0d hi", k), 64'(eHi), 64'(expHi[7:0]));
      checkOutput($sformatf("rand%0d lo", k), 64'(eLo), 64'(expLo[7:0]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit with architectural HI/LO registers for the MIPS datapath. It executes the mult/div, mfhi/mflo and mthi/mtlo operations flagged by the ALU decoder. Signed and unsigned modes are supported at configurable width. While an operation is in flight it raises busy/stall, and the pipeline holds any dependent HI/LO access.

## Interface
Parameters:
- WIDTH, 32, operand/HI/LO width; ≥4, even.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start_mult  in  1  start multiply (from decoder mult); sampled when idle.
- start_div  in  1  start divide (from decoder div); sampled when idle.
- is_signed  in  1  0 = multu/divu, 1 = mult/div; sampled with start.
- abort  in  1  synchronous cancel of an in-flight operation.
- srca  in  WIDTH  multiplicand / dividend.
- srcb  in  WIDTH  multiplier / divisor.
- rd_hi  in  1  mfhi request (decoder movhi).
- rd_lo  in  1  mflo request (decoder movlo).
- wr_hi  in  1  mthi: HI <= srca.
- wr_lo  in  1  mtlo: LO <= srca.
- result  out  WIDTH  HI if rd_hi, else LO if rd_lo, else 0 (combinational).
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- busy  out  1  operation in flight (registered).
- done  out  1  one-cycle pulse; HI/LO just updated by mult/div.
- stall  out  1  busy & (rd_hi|rd_lo|wr_hi|wr_lo|start_mult|start_div).

## Operation
- States: IDLE, MUL, DIV, FIX. Reset → IDLE; hi=0, lo=0, busy=0, done=0, iteration counter=0.
- Start in IDLE:
  - start_mult wins if both starts are asserted.
  - Operands latched. In signed mode they are latched as magnitudes, with result-sign and remainder-sign flags captured.
  - Next state MUL/DIV; counter=0.
- MUL: radix-2 shift-add, one bit per cycle, 2·WIDTH-bit accumulator.
- DIV: restoring division, one quotient bit per cycle.
- Both MUL and DIV run exactly WIDTH iterations, then go to FIX.
- FIX, unconditional even in unsigned mode:
  - Negate the product, quotient and/or remainder as required.
  - Write HI/LO; done=1 for the following cycle; go to IDLE.
- Multiply result: {HI,LO} = full 2·WIDTH-bit product.
- Divide result: LO = quotient, truncated toward zero. HI = remainder, with the sign of the dividend.
- Divide by zero (either mode): LO = all-ones, HI = srca unchanged, no sign fixup.
- Signed overflow (most-negative / −1): LO = most-negative, HI = 0.
- wr_hi/wr_lo in IDLE: write srca on the edge. Both may be asserted together.
- wr_hi/wr_lo together with a start in the same IDLE cycle: the write occurs; the later FIX overwrites it.
- start, wr or rd while busy: ignored, stall=1. There is no queue; upstream must hold the request.
- rd_hi and rd_lo both asserted: HI is returned.
- abort in MUL/DIV/FIX: return to IDLE next edge; HI/LO unchanged; no done.
- abort in IDLE: no effect, and any start in that cycle is suppressed.
- reset_n low at any time: immediate return to reset values; in-flight result discarded.

## Timing
- Start sampled at edge E. busy=1 from after E through edge E+WIDTH+1 (WIDTH+1 cycles).
- HI/LO are updated at edge E+WIDTH+1, and done=1 in the cycle after it.
- The earliest next start is the cycle after E+WIDTH+1, i.e. while done=1. Back-to-back operations are allowed.
- Timing for WIDTH=32: 33 busy cycles; result visible 33 cycles after the start edge.
- result, stall: combinational from current inputs and registered state. No combinational path from srca/srcb to busy/done.

## Test plan
- Unsigned multiply, WIDTH=32: start_mult, is_signed=0, 0xFFFFFFFF×0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001, done at E+33, busy high exactly 33 cycles.
- Signed multiply and divide:
  - −3×5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1.
  - −7÷2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu 7÷2 → LO=3, HI=1.
- Corner divides:
  - 100÷0 → LO=0xFFFFFFFF, HI=0x00000064.
  - Signed 0x80000000÷0xFFFFFFFF → LO=0x80000000, HI=0.
- Hazards:
  - rd_lo held from E+1: stall=1 until done; result=LO on the done cycle.
  - start_div at E+5 is ignored; HI/LO reflect only the first operation.
- Control:
  - mthi 0x1234 then mfhi → result=0x1234.
  - abort at E+10 → busy=0 at E+11, HI/LO unchanged, no done.
  - reset_n low at E+20 → hi=lo=0, busy=0 immediately.
- WIDTH=8 instance, randomized signed and unsigned ops against a reference model: busy is 9 cycles and all results match.
